param_serializer: RTL
=====================

# param_serializer

Parametrised parallel-to-serial transmitter with a programmable bit-clock divider, selectable bit order and a one-word holding register for gap-free back-to-back frames. It sits between a parallel producer (store/empty handshake) and an external serial link. It drives the link's serial clock and data lines, and it succeeds the fixed 8-bit serializers.

## Interface
- WIDTH, 8, data bits per frame (≥2)
- DIV_WIDTH, 16, width of divider input and internal divide counter
- clock  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous, active-high reset
- par_data  in  WIDTH  word to transmit, sampled when accepted
- store  in  1  write strobe; accepted only when empty=1
- divider  in  DIV_WIDTH  half-bit period minus one, in clock cycles
- msb_first  in  1  0 = LSB first, 1 = MSB first
- ser_clock  out  1  serial bit clock
- ser_data  out  1  serial data; valid at ser_clock rising edge
- empty  out  1  holding register free
- busy  out  1  frame shifting
- done  out  1  one-cycle pulse at frame end

Clock and reset: one clock; reset is asynchronous and active-high.

## Operation
- Storage: holding register (WIDTH bits plus valid flag) and shift register (WIDTH bits, plus latched divider and msb_first).
- Accept: at a posedge with store=1 and empty=1, par_data is loaded into the holding register and empty goes 0. A store while empty=0 is ignored; no data is corrupted.
- Load: when the shifter is free (IDLE, or last bit period just finished) and the holding register is valid, the holding register moves into the shifter at that posedge. The same edge latches divider and msb_first, sets empty=1 and starts bit 0.
- States: IDLE and SHIFT. With SERIALIZER_PARITY_EN, a PARITY state follows SHIFT.
  - IDLE→SHIFT on load.
  - SHIFT→SHIFT on load at frame end (back-to-back).
  - SHIFT→IDLE at frame end if no word is held.
- Bit period: 2·(D+1) cycles, where D is the latched divider.
  - ser_clock is 0 for the first D+1 cycles and 1 for the last D+1 cycles.
  - ser_data changes only at the start of a bit period.
- Bit order: LSB first yields par_data[0] through [WIDTH-1]. MSB first yields the reverse.
- Counters:
  - Divide counter is DIV_WIDTH bits; it wraps to 0 at each half-period end.
  - Bit counter is clog2(WIDTH+1) bits.
  - D = all-ones is legal, with no overflow (compare, not add).
- Idle outputs: ser_clock=0, ser_data=0, busy=0.
- Changes to divider or msb_first mid-frame take effect only at the next load.

## Timing
- Reset values: ser_clock=0, ser_data=0, empty=1, busy=0, done=0. State IDLE; holding register invalid; counters 0.
- Reset mid-frame aborts at once; the held word is discarded.
- Store to first bit: store sampled at edge n → empty=0 after n.
  - Edge n+1 loads the shifter: empty=1, busy=1, ser_data = first bit, ser_clock=0.
- Frame length: WIDTH·2·(D+1) cycles, or (WIDTH+1)·2·(D+1) with parity.
- done is high for exactly one cycle, following the edge that ends the last bit's high half.
- Back-to-back: a word held at frame end starts on the same edge as done.
  - No idle cycle; busy stays 1.
  - ser_clock falls exactly as between bits.
- Store at the same edge as a load: not accepted, because empty is still 0 at that edge. It is accepted one cycle later.

## Configuration
- SERIALIZER_PARITY_EN defined: one extra bit period follows the data bits.
  - ser_data = even parity (XOR of all WIDTH data bits), timed like a data bit.
  - done and any back-to-back load move to the end of the parity bit.
- Not defined: frames are exactly WIDTH bits. No PARITY state exists.

## Test plan
- Reset check: assert reset mid-frame (WIDTH=8, D=1, 8'hFF after 3 bits) → all outputs take reset values asynchronously, before the next posedge. After release, empty=1 and there is no further ser_clock activity.
- LSB first: D=0, msb_first=0, store 8'hA5 → from edge n+1, ser_data = 1,0,1,0,0,1,0,1 with each bit held 2 cycles. ser_clock = 0,1 per bit; done pulses 16 cycles after load.
- MSB first, slow clock: D=2, msb_first=1, store 8'h81 → bits 1,0,0,0,0,0,0,1, each 6 cycles. ser_clock shows 3 low then 3 high per bit.
- Back-to-back: store 8'h0F, then store 8'hF0 once empty returns to 1 → 16 contiguous bit periods with no gap. busy stays 1; one done pulse after bit 8 and another after bit 16.
- Overrun: while a frame shifts and a word is held (empty=0), store 8'h3C → ignored. Only the two earlier words appear on ser_data.
- Parity (with SERIALIZER_PARITY_EN, D=0): store 8'h07 → 9th bit is 1; done arrives 18 cycles after load. Store 8'h03 → 9th bit is 0.

Source files
------------

// File: rtl/param_serializer.sv
// -----------------------------------------------------------------------------
// param_serializer
//
// Parallel-to-serial transmitter with a programmable bit-clock divider,
// selectable bit order and a one-word holding register.
//
// A producer writes a word with store while empty=1. The word waits in the
// holding register until the shifter is free. It then moves into the shifter
// and is sent one bit per bit period. A word held when a frame ends starts on
// that same edge, so back-to-back frames have no gap.
//
// Bit period = 2*(D+1) clock cycles, where D is the divider value latched at
// load. ser_clock is low for the first half and high for the second half.
// ser_data changes only at the start of a bit period.
//
// Build option:
//   SERIALIZER_PARITY_EN - appends one even-parity bit (XOR of the data bits)
//                          after the data bits, timed like a data bit.
//
// Parameters:
//   WIDTH      data bits per frame (>= 2)
//   DIV_WIDTH  width of the divider input and of the divide counter
//
// Ports:
//   clock      system clock, all logic on posedge
//   reset      asynchronous, active-high reset
//   par_data   word to transmit, sampled when accepted
//   store      write strobe, accepted only while empty=1
//   divider    half-bit period minus one, in clock cycles
//   msb_first  0 = LSB first, 1 = MSB first
//   ser_clock  serial bit clock
//   ser_data   serial data, valid at the ser_clock rising edge
//   empty      holding register free
//   busy       frame shifting
//   done       one-cycle pulse at frame end
// -----------------------------------------------------------------------------
module param_serializer #(
   parameter int WIDTH     = 8,
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     par_data,
   input  logic                 store,
   input  logic [DIV_WIDTH-1:0] divider,
   input  logic                 msb_first,
   output logic                 ser_clock,
   output logic                 ser_data,
   output logic                 empty,
   output logic                 busy,
   output logic                 done
);

   localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

   state_t                 state;
   state_t                 state_nxt;

   logic [WIDTH-1:0]       hold_data;
   logic                   hold_valid;
   logic [WIDTH-1:0]       shift_reg;
   logic [WIDTH-1:0]       shift_nxt;
   logic [DIV_WIDTH-1:0]   div_lat;
   logic                   msb_lat;
   logic [DIV_WIDTH-1:0]   div_cnt;
   logic [CNT_W-1:0]       bit_cnt;
   logic                   phase;      // 0 = low half, 1 = high half of the bit
   logic                   data_bit;
   logic                   done_q;
`ifdef SERIALIZER_PARITY_EN
   logic                   parity_lat;
`endif

   logic                   half_end;
   logic                   period_end;
   logic                   last_bit;
   logic                   frame_end;
   logic                   load;

   // Timing decodes. Comparing against the latched divider (rather than
   // adding one to it) keeps D = all-ones free of overflow.
   always_comb begin
      // NOTE: every signal gets a value on every path of a combinational block,
      // otherwise synthesis infers a latch.
      half_end   = (div_cnt == div_lat);
      period_end = (state != IDLE) && phase && half_end;
      last_bit   = (bit_cnt == CNT_W'(WIDTH - 1));
`ifdef SERIALIZER_PARITY_EN
      frame_end  = (state == PARITY) && period_end;
`else
      frame_end  = (state == SHIFT) && period_end && last_bit;
`endif
      // The shifter takes the held word when idle or on the edge that ends a
      // frame, which is what makes back-to-back frames gap-free.
      load       = hold_valid && ((state == IDLE) || frame_end);
      shift_nxt  = msb_lat ? (shift_reg << 1) : (shift_reg >> 1);
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the values from before the edge.
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (load) state_nxt = SHIFT;
         end
         SHIFT: begin
`ifdef SERIALIZER_PARITY_EN
            if (period_end && last_bit) state_nxt = PARITY;
`else
            if (frame_end) state_nxt = load ? SHIFT : IDLE;
`endif
         end
`ifdef SERIALIZER_PARITY_EN
         PARITY: begin
            if (frame_end) state_nxt = load ? SHIFT : IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy      = (state != IDLE);
      ser_clock = busy && phase;
      ser_data  = data_bit;
      done      = done_q;
      empty     = !hold_valid;
   end

   // Holding register, shifter and counters
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold_data  <= '0;
         hold_valid <= 1'b0;
         shift_reg  <= '0;
         div_lat    <= '0;
         msb_lat    <= 1'b0;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         phase      <= 1'b0;
         data_bit   <= 1'b0;
         done_q     <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         parity_lat <= 1'b0;
`endif
      end else begin
         done_q <= frame_end;

         // Accept and load are mutually exclusive: accept needs an empty
         // holding register, load needs a full one.
         if (store && !hold_valid) begin
            hold_data  <= par_data;
            hold_valid <= 1'b1;
         end else if (load) begin
            hold_valid <= 1'b0;
         end

         if (load) begin
            shift_reg  <= hold_data;
            div_lat    <= divider;
            msb_lat    <= msb_first;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            phase      <= 1'b0;
            data_bit   <= msb_first ? hold_data[WIDTH-1] : hold_data[0];
`ifdef SERIALIZER_PARITY_EN
            parity_lat <= ^hold_data;
`endif
         end else if (state != IDLE) begin
            if (half_end) begin
               div_cnt <= '0;
               phase   <= !phase;
               if (phase) begin
                  if (frame_end) begin
                     data_bit <= 1'b0;
                     bit_cnt  <= '0;
`ifdef SERIALIZER_PARITY_EN
                  end else if (last_bit) begin
                     data_bit <= parity_lat;
`endif
                  end else begin
                     shift_reg <= shift_nxt;
                     data_bit  <= msb_lat ? shift_nxt[WIDTH-1] : shift_nxt[0];
                     bit_cnt   <= bit_cnt + CNT_W'(1);
                  end
               end
            end else begin
               div_cnt <= div_cnt + DIV_WIDTH'(1);
            end
         end
      end
   end

endmodule
